// File: rtl/dmem_strb_mp_pkg.sv
// Shared types and byte-merge helper for the strobed multi-read-port data memory.
// Merge helper works on a maximum-width word; callers zero-extend and truncate.
package dmem_pkg;

  localparam int DMEM_MAX_W = 256;
  localparam int DMEM_MAX_B = DMEM_MAX_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

  function automatic logic [DMEM_MAX_W-1:0] byte_merge(
    input logic [DMEM_MAX_W-1:0] old_word,
    input logic [DMEM_MAX_W-1:0] new_word,
    input logic [DMEM_MAX_B-1:0] strb
  );
    logic [DMEM_MAX_W-1:0] res;
    res = old_word;
    for (int k = 0; k < DMEM_MAX_B; k++) begin
      if (strb[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_strb_mp_if.sv
// Load/store-unit <-> data-memory bus: one strobed write port, NRD packed read ports.
// master = requester side, slave = memory side.
interface dmem_strb_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                 we0;
  logic [AW-1:0]        wr_addr0;
  logic [WIDTH-1:0]     wr_din0;
  logic [WIDTH/8-1:0]   wr_strb;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_dout;
  logic [NRD-1:0]       rd_valid;
  logic                 init_done;

  modport master (
    output we0, wr_addr0, wr_din0, wr_strb, rd_en, rd_addr,
    input  rd_dout, rd_valid, init_done
  );

  modport slave (
    input  we0, wr_addr0, wr_din0, wr_strb, rd_en, rd_addr,
    output rd_dout, rd_valid, init_done
  );
endinterface

// File: rtl/dmem_clear_fsm.sv
// CLEAR/READY sequencer: walks every word address once after reset, then signals init_done.
// init_done rises after exactly DEPTH non-reset edges.
module dmem_clear_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  output logic                     clr_en,
  output logic [$clog2(DEPTH)-1:0] clr_addr
);
  localparam int AW = $clog2(DEPTH);

  dmem_state_t   state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + AW'(1);
      if (cnt == AW'(DEPTH - 1)) state_nxt = READY;
    end
  end

  always_comb begin
    init_done = (state == READY);
    clr_en    = (state == CLEAR);
    clr_addr  = cnt;
  end

endmodule

// File: rtl/dmem_strb_mp.sv
// Word-addressed RAM: one byte-strobed write port, NRD registered read ports, self-clear after reset.
// `define DMEM_BYPASS_EN makes a same-edge read of the written address return the merged word.
module dmem_strb_mp
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int NRD   = 2
) (
  input  logic          clk,
  input  logic          rst,
  dmem_strb_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0]           mem [DEPTH];
  logic                       ready;
  logic                       clr_en;
  logic [AW-1:0]              clr_addr;
  logic [WIDTH-1:0]           wr_merged;
  logic [NRD-1:0][AW-1:0]     addr_v;
  logic [NRD-1:0][WIDTH-1:0]  rd_word;
  logic [NRD-1:0][WIDTH-1:0]  dout_q;
  logic [NRD-1:0]             valid_q;

  dmem_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clk       (clk),
    .rst       (rst),
    .init_done (ready),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NB-1:0]    strb
  );
    logic [DMEM_MAX_W-1:0] o, n, r;
    logic [DMEM_MAX_B-1:0] s;
    o = '0;
    n = '0;
    s = '0;
    o[WIDTH-1:0] = old_word;
    n[WIDTH-1:0] = new_word;
    s[NB-1:0]    = strb;
    r = byte_merge(o, n, s);
    return r[WIDTH-1:0];
  endfunction

  assign addr_v    = bus.rd_addr;
  assign wr_merged = merge_w(mem[bus.wr_addr0], bus.wr_din0, bus.wr_strb);

  // Clear sequence owns the write port until READY; user writes are dropped meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (clr_en) begin
        mem[clr_addr] <= '0;
      end else if (bus.we0) begin
        mem[bus.wr_addr0] <= wr_merged;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_word[i] = mem[addr_v[i]];
`ifdef DMEM_BYPASS_EN
      if (bus.we0 && (addr_v[i] == bus.wr_addr0)) rd_word[i] = wr_merged;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        valid_q[i] <= ready && bus.rd_en[i];
        if (ready && bus.rd_en[i]) dout_q[i] <= rd_word[i];
      end
    end
  end

  assign bus.rd_dout   = dout_q;
  assign bus.rd_valid  = valid_q;
  assign bus.init_done = ready;

endmodule

// File: tb/tb_dmem_strb_mp.sv
// Randomised + directed bench for dmem_strb_mp against a word-array reference model.
// Model tracks edges since reset, memory contents and expected read registers.
module tb_dmem_strb_mp;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int NRD   = 2;

  logic clk;
  logic rst;

  dmem_strb_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) bus ();

  dmem_strb_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mm [DEPTH];
  bit          m_ready;
  int          m_edges;
  logic [31:0] m_dout [NRD];
  logic [1:0]  m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] st);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic model_edge(input bit r, input bit we, input logic [6:0] wa, input logic [31:0] wd,
                            input logic [3:0] st, input logic [1:0] ren, input logic [6:0] a0,
                            input logic [6:0] a1);
    logic [6:0]  ra [NRD];
    logic [31:0] v;
    ra[0] = a0;
    ra[1] = a1;
    if (!r) begin
      m_ready = 0;
      m_edges = 0;
      m_valid = '0;
      for (int i = 0; i < NRD; i++) m_dout[i] = '0;
    end else if (!m_ready) begin
      mm[m_edges] = '0;
      m_edges++;
      if (m_edges == DEPTH) m_ready = 1;
      m_valid = '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        m_valid[i] = ren[i];
        if (ren[i]) begin
          v = mm[ra[i]];
`ifdef DMEM_BYPASS_EN
          if (we && wa == ra[i]) v = apply_strb(v, wd, st);
`endif
          m_dout[i] = v;
        end
      end
      if (we) mm[wa] = apply_strb(mm[wa], wd, st);
    end
  endtask

  // One clock: drive, advance model at the edge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit we, input logic [6:0] wa, input logic [31:0] wd,
                     input logic [3:0] st, input logic [1:0] ren, input logic [6:0] a0,
                     input logic [6:0] a1);
    rst          = r;
    bus.we0      = we;
    bus.wr_addr0 = wa;
    bus.wr_din0  = wd;
    bus.wr_strb  = st;
    bus.rd_en    = ren;
    bus.rd_addr  = {a1, a0};
    @(posedge clk);
    model_edge(r, we, wa, wd, st, ren, a0, a1);
    #1;
    check("init_done", {31'b0, bus.init_done}, {31'b0, m_ready});
    check("rd_valid", {30'b0, bus.rd_valid}, {30'b0, m_valid});
    check("rd_dout0", bus.rd_dout[31:0], m_dout[0]);
    check("rd_dout1", bus.rd_dout[63:32], m_dout[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    logic [31:0] coll_exp;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    m_ready = 0;
    m_edges = 0;
    m_valid = '0;
    for (int i = 0; i < NRD; i++) m_dout[i] = '0;
    rst = 0; bus.we0 = 0; bus.wr_addr0 = '0; bus.wr_din0 = '0; bus.wr_strb = '0;
    bus.rd_en = '0; bus.rd_addr = '0;

    // Reset release and clear sequence
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(127);
    check("init_done_127", {31'b0, bus.init_done}, 32'd0);
    idle(1);
    check("init_done_128", {31'b0, bus.init_done}, 32'd1);
    cyc(1, 0, 0, 0, 0, 2'b11, 7'd5, 7'd5);
    check("clr_rd0", bus.rd_dout[31:0], 32'h0);
    check("clr_rd1", bus.rd_dout[63:32], 32'h0);
    check("clr_valid", {30'b0, bus.rd_valid}, 32'd3);

    // Full word write
    cyc(1, 1, 7'd0, 32'h12345678, 4'hF, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0, 2'b01, 7'd0, 0);
    check("full_word", bus.rd_dout[31:0], 32'h12345678);
    check("full_valid", {30'b0, bus.rd_valid}, 32'd1);

    // Byte lanes
    cyc(1, 1, 7'd1, 32'h000000AA, 4'b0001, 2'b00, 0, 0);
    cyc(1, 1, 7'd1, 32'h0000BB00, 4'b0010, 2'b00, 0, 0);
    cyc(1, 1, 7'd1, 32'h00CC0000, 4'b0100, 2'b00, 0, 0);
    cyc(1, 1, 7'd1, 32'hDD000000, 4'b1000, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0, 2'b01, 7'd1, 0);
    check("byte_lanes", bus.rd_dout[31:0], 32'hDDCCBBAA);

    // Halfwords, two ports in one cycle
    cyc(1, 1, 7'd2, 32'h00001234, 4'b0011, 2'b00, 0, 0);
    cyc(1, 1, 7'd2, 32'h56780000, 4'b1100, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0, 2'b11, 7'd1, 7'd2);
    check("half_p0", bus.rd_dout[31:0], 32'hDDCCBBAA);
    check("half_p1", bus.rd_dout[63:32], 32'h56781234);

    // Same-address read and write
`ifdef DMEM_BYPASS_EN
    coll_exp = 32'h123456FF;
`else
    coll_exp = 32'h12345678;
`endif
    cyc(1, 1, 7'd0, 32'h000000FF, 4'b0001, 2'b01, 7'd0, 0);
    check("collision", bus.rd_dout[31:0], coll_exp);
    cyc(1, 0, 0, 0, 0, 2'b01, 7'd0, 0);
    check("after_coll", bus.rd_dout[31:0], 32'h123456FF);

    // Strobe 0 is a no-op
    cyc(1, 1, 7'd2, 32'hFFFFFFFF, 4'b0000, 2'b00, 0, 0);
    cyc(1, 0, 0, 0, 0, 2'b10, 0, 7'd2);
    check("strb_zero", bus.rd_dout[63:32], 32'h56781234);

    // Reset pulse, write during clear is dropped
    cyc(0, 0, 0, 0, 0, 2'b11, 0, 0);
    check("rst_done", {31'b0, bus.init_done}, 32'd0);
    check("rst_valid", {30'b0, bus.rd_valid}, 32'd0);
    check("rst_dout0", bus.rd_dout[31:0], 32'h0);
    check("rst_dout1", bus.rd_dout[63:32], 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 50) cyc(1, 1, 7'd2, 32'hFFFFFFFF, 4'hF, 2'b11, 7'd2, 7'd1);
      else         idle(1);
    end
    check("reclr_done", {31'b0, bus.init_done}, 32'd1);
    cyc(1, 0, 0, 0, 0, 2'b11, 7'd0, 7'd1);
    check("reclr_a0", bus.rd_dout[31:0], 32'h0);
    check("reclr_a1", bus.rd_dout[63:32], 32'h0);
    cyc(1, 0, 0, 0, 0, 2'b01, 7'd2, 0);
    check("reclr_a2", bus.rd_dout[31:0], 32'h0);

    // Random traffic on a small address window, with rare resets
    for (int n = 0; n < 1500; n++) begin
      bit          r;
      logic [6:0]  wa, a0, a1;
      r  = ($urandom_range(0, 299) != 0);
      wa = 7'($urandom_range(0, 7));
      a0 = 7'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 7'($urandom_range(0, 7));
      cyc(r, 1'($urandom), wa, $urandom, 4'($urandom), 2'($urandom), a0, a1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
